// File: rtl/axi_lite_bridge_mc_pkg.sv
// Shared types and defaults for the multi-channel AXI-lite DRAM bridge.
package bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} bridge_state_e;

  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam logic [16:0] DEF_BASE_ADDR   = 17'h10000;
  localparam int          DEF_STRIDE_LOG2 = 3;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_lite_bridge_mc_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer
// moves to winner+1 whenever a grant is consumed.
module rr_arbiter import bridge_pkg::*; #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 advance_i,
  output logic [N-1:0]         grant_oh_o,
  output logic [idx_w(N)-1:0]  grant_idx_o,
  output logic                 any_o
);
  localparam int IW = idx_w(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Scan from farthest to nearest so the nearest requester is assigned last.
  always_comb begin
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr_q) + k) % N);
      if (req_i[cand]) begin
        grant_idx_o = cand;
        any_o       = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh_o = '0;
    if (any_o) grant_oh_o[grant_idx_o] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (advance_i && any_o)
      ptr_q <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
  end
endmodule

// File: rtl/axi_lite_bridge_mc.sv
// N_CH client channels sharing one AXI-lite DRAM master, one transaction at a
// time, round-robin granted, with per-channel request latching.
module axi_lite_bridge_mc import bridge_pkg::*; #(
  parameter int                    N_CH        = 2,
  parameter int                    DATA_W      = 64,
  parameter int                    ADDR_W      = 8,
  parameter int                    AXI_ADDR_W  = 17,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int                    STRIDE_LOG2 = DEF_STRIDE_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          C_in_valid,
  input  logic [N_CH-1:0]          C_r_wb,
  input  logic [N_CH*ADDR_W-1:0]   C_addr,
  input  logic [N_CH*DATA_W-1:0]   C_data_w,
  output logic [N_CH-1:0]          C_out_valid,
  output logic [DATA_W-1:0]        C_data_r,
  output logic                     C_err,
  output logic                     AR_VALID,
  input  logic                     AR_READY,
  output logic [AXI_ADDR_W-1:0]    AR_ADDR,
  input  logic                     R_VALID,
  output logic                     R_READY,
  input  logic [DATA_W-1:0]        R_DATA,
  input  logic [1:0]               R_RESP,
  output logic                     AW_VALID,
  input  logic                     AW_READY,
  output logic [AXI_ADDR_W-1:0]    AW_ADDR,
  output logic                     W_VALID,
  input  logic                     W_READY,
  output logic [DATA_W-1:0]        W_DATA,
  input  logic                     B_VALID,
  output logic                     B_READY,
  input  logic [1:0]               B_RESP
);
  localparam int IW = idx_w(N_CH);

  logic [N_CH-1:0]             pend_q, rwb_q;
  logic [N_CH-1:0][ADDR_W-1:0] addr_q;
  logic [N_CH-1:0][DATA_W-1:0] wdat_q;

  bridge_state_e         state_q;
  logic [N_CH-1:0]       gnt_oh_q, arb_oh;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any, arb_adv;
  logic [AXI_ADDR_W-1:0] sel_addr;
  logic                  aw_done_q, w_done_q, aw_hs, w_hs, err_q;
  logic [DATA_W-1:0]     res_q;

  logic [N_CH-1:0]       C_out_valid_q;
  logic [DATA_W-1:0]     C_data_r_q, W_DATA_q;
  logic                  C_err_q, AR_VALID_q, R_READY_q, AW_VALID_q, W_VALID_q, B_READY_q;
  logic [AXI_ADDR_W-1:0] AR_ADDR_q, AW_ADDR_q;

  assign arb_adv  = (state_q == IDLE) && arb_any;
  // Shift happens at the DRAM width so oversized records wrap modulo 2^AXI_ADDR_W.
  assign sel_addr = BASE_ADDR + (AXI_ADDR_W'(addr_q[arb_idx]) << STRIDE_LOG2);
  assign aw_hs    = AW_VALID_q && AW_READY;
  assign w_hs     = W_VALID_q && W_READY;

  rr_arbiter #(.N(N_CH)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (pend_q),
    .advance_i  (arb_adv),
    .grant_oh_o (arb_oh),
    .grant_idx_o(arb_idx),
    .any_o      (arb_any)
  );

  // Clearing happens in DONE, so a pulse in the C_out_valid cycle finds pend=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      rwb_q  <= '0;
      addr_q <= '0;
      wdat_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (C_in_valid[i] && !pend_q[i]) begin
          pend_q[i] <= 1'b1;
          rwb_q[i]  <= C_r_wb[i];
          addr_q[i] <= C_addr[i*ADDR_W +: ADDR_W];
          wdat_q[i] <= C_data_w[i*DATA_W +: DATA_W];
        end else if (state_q == DONE && gnt_oh_q[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_oh_q      <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      err_q         <= 1'b0;
      res_q         <= '0;
      C_out_valid_q <= '0;
      C_data_r_q    <= '0;
      C_err_q       <= 1'b0;
      AR_VALID_q    <= 1'b0;
      AR_ADDR_q     <= '0;
      R_READY_q     <= 1'b0;
      AW_VALID_q    <= 1'b0;
      AW_ADDR_q     <= '0;
      W_VALID_q     <= 1'b0;
      W_DATA_q      <= '0;
      B_READY_q     <= 1'b0;
    end else begin
      C_out_valid_q <= '0;
      case (state_q)
        IDLE: if (arb_any) begin
          gnt_oh_q <= arb_oh;
          if (rwb_q[arb_idx]) begin
            AR_VALID_q <= 1'b1;
            AR_ADDR_q  <= sel_addr;
            state_q    <= RD_A;
          end else begin
            AW_VALID_q <= 1'b1;
            W_VALID_q  <= 1'b1;
            AW_ADDR_q  <= sel_addr;
            W_DATA_q   <= wdat_q[arb_idx];
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            state_q    <= WR_AW;
          end
        end
        RD_A: if (AR_READY) begin
          AR_VALID_q <= 1'b0;
          R_READY_q  <= 1'b1;
          state_q    <= RD_D;
        end
        RD_D: if (R_VALID) begin
          res_q     <= R_DATA;
          err_q     <= (R_RESP != RESP_OKAY);
          R_READY_q <= 1'b0;
          state_q   <= DONE;
        end
        WR_AW: begin
          if (aw_hs) begin
            AW_VALID_q <= 1'b0;
            aw_done_q  <= 1'b1;
          end
          if (w_hs) begin
            W_VALID_q <= 1'b0;
            w_done_q  <= 1'b1;
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            B_READY_q <= 1'b1;
            state_q   <= WR_B;
          end
        end
        WR_B: if (B_VALID) begin
          res_q     <= W_DATA_q;
          err_q     <= (B_RESP != RESP_OKAY);
          B_READY_q <= 1'b0;
          state_q   <= DONE;
        end
        DONE: begin
          C_out_valid_q <= gnt_oh_q;
          C_data_r_q    <= res_q;
          C_err_q       <= err_q;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign C_out_valid = C_out_valid_q;
  assign C_data_r    = C_data_r_q;
  assign C_err       = C_err_q;
  assign AR_VALID    = AR_VALID_q;
  assign AR_ADDR     = AR_ADDR_q;
  assign R_READY     = R_READY_q;
  assign AW_VALID    = AW_VALID_q;
  assign AW_ADDR     = AW_ADDR_q;
  assign W_VALID     = W_VALID_q;
  assign W_DATA      = W_DATA_q;
  assign B_READY     = B_READY_q;
endmodule

// File: doc/axi_lite_bridge_mc.md
Name: axi_lite_bridge_mc

Overview:
- Multi-channel successor to the single-client pokemon/DRAM bridge.
- N_CH client channels, each a C_* request interface, share one AXI-lite-style DRAM master port (AR/R/AW/W/B).
- Round-robin arbitration, per-channel request latching, parametrised widths and base address, response-error reporting.
- Sits between up to N_CH compute blocks and the DRAM model.

Parameters:
- N_CH, 2, number of client channels (1..8)
- DATA_W, 64, data width of client and DRAM buses
- ADDR_W, 8, client address width (record index)
- AXI_ADDR_W, 17, DRAM address width
- BASE_ADDR, 17'h10000, DRAM byte address of record 0
- STRIDE_LOG2, 3, log2 byte stride per record (8 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- C_in_valid  in  N_CH  per-channel 1-cycle request pulse
- C_r_wb  in  N_CH  1 = read, 0 = write, sampled with C_in_valid
- C_addr  in  N_CH*ADDR_W  per-channel record index, packed; ch0 in LSBs
- C_data_w  in  N_CH*DATA_W  per-channel write data, packed
- C_out_valid  out  N_CH  one-hot 1-cycle completion pulse
- C_data_r  out  DATA_W  read data (read) / written data echo (write); valid with C_out_valid
- C_err  out  1  RESP != 2'b00 on the completed transaction; valid with C_out_valid
- AR_VALID/AR_READY  out/in  1/1
- AR_ADDR  out  AXI_ADDR_W
- R_VALID/R_READY  in/out  1/1
- R_DATA  in  DATA_W
- R_RESP  in  2
- AW_VALID/AW_READY  out/in  1/1
- AW_ADDR  out  AXI_ADDR_W
- W_VALID/W_READY  out/in  1/1
- W_DATA  out  DATA_W
- B_VALID/B_READY  in/out  1/1
- B_RESP  in  2

Behaviour:
- Single clock clk. rst is synchronous, active-high.
- Reset values: all outputs 0. pending[] = 0. RR pointer = 0. FSM = IDLE.
- Request latch: C_in_valid[i] high and pending[i] = 0 sets pending[i] and captures r_wb, addr and data for channel i.
  - C_in_valid[i] while pending[i] = 1 is ignored; the latched request is unchanged.
  - A pulse in the same cycle as the channel's own C_out_valid is accepted as a new request.
- Address: AXI addr = BASE_ADDR + (addr << STRIDE_LOG2), truncated to AXI_ADDR_W (wraps modulo 2^AXI_ADDR_W).
- Arbitration (IDLE): grant the first pending channel at or after ptr, searching cyclically. ptr is set to grant+1 mod N_CH after each grant. A request latched in cycle t is eligible in cycle t+1.
- FSM states:
  - IDLE: any pending -> grant -> RD_A if read, else WR_AW.
  - RD_A: AR_VALID=1 with AR_ADDR held stable. AR_VALID && AR_READY -> RD_D.
  - RD_D: R_READY=1. R_VALID -> capture R_DATA and R_RESP -> DONE.
  - WR_AW: AW_VALID=1 and W_VALID=1 together, W_DATA = latched data.
    - Each VALID drops independently the cycle after its own handshake.
    - When both have handshaken (same or different cycles) -> WR_B.
  - WR_B: B_READY=1. B_VALID -> capture B_RESP -> DONE.
  - DONE: for one cycle, C_out_valid[grant]=1, C_data_r driven, C_err driven. pending[grant] cleared. -> IDLE.
- Outputs are registered. Between completions, C_data_r holds its last value.
- Latency: grant cycle is t, with VALID asserted from t+1.
  - Read, DRAM always ready with data 1 cycle after AR: C_out_valid at t+4.
  - Write, same conditions: C_out_valid at t+4.
- VALID never drops before its handshake. ADDR and DATA are stable while VALID is high.
- R_VALID or B_VALID arriving outside RD_D or WR_B is ignored; the DRAM model is protocol-compliant.
- Reset mid-transaction: next edge returns to IDLE, clears pending[] and ptr, drops all VALID/READY. The DRAM model must be reset in the same cycle.
- N_CH=1: arbiter degenerates to a pass-through, ptr stays 0.

Decomposition:
- Package bridge_pkg:
  - typedef enum {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} bridge_state_e
  - RESP_OKAY = 2'b00
  - Default BASE_ADDR and STRIDE_LOG2 constants.
- Sub-module rr_arbiter, parameter N.
  - Inputs: req[N], advance.
  - Outputs: grant_oh[N], grant_idx, any.
  - Internal pointer update on advance.

Test Plan:
- Reset, then ch0 read addr 8'h05, DRAM returns 64'hDEAD_BEEF_0000_0001 with RESP 0 -> AR_ADDR=17'h10028; C_out_valid=2'b01, C_data_r=64'hDEAD_BEEF_0000_0001, C_err=0 at grant+4.
- Ch1 write addr 8'hFF, data 64'h1234; AW_READY delayed 3 cycles, W_READY immediate -> W_VALID drops after 1 cycle, AW_VALID held 4 cycles with AW_ADDR=17'h107F8; C_out_valid=2'b10, echo 64'h1234.
- Both channels pulse in the same cycle, repeated 4 times -> grant order ch0, ch1, ch0, ch1. No channel starved.
- Read with R_RESP=2'b10 -> C_err=1 with C_out_valid; pending cleared; next request proceeds normally.
- Ch0 re-pulses while pending with a different addr -> original addr is the one issued; the second pulse is dropped.
- rst asserted during WR_B with B_VALID low -> next cycle all outputs 0 and FSM IDLE; a new ch1 read then completes correctly.
